// File: rtl/contador_param.sv
// -----------------------------------------------------------------------------
// contador_param
//
// Purpose:
//   Per-channel accepted-pop counter for the transaction-layer FIFO bank.
//   Each of NUM_CH channels counts pops that hit a non-empty FIFO while the
//   link is IDLE or ACTIVE. A count saturates at 2**CNT_W-1, and any further
//   accepted pop on that channel sets its sticky overflow flag. A small
//   WAIT/SERVE readout FSM answers req/idx requests while the link is IDLE.
//   The answer appears exactly one cycle after the request and can be
//   streamed back-to-back, one channel per cycle.
//
// Parameters:
//   NUM_CH : number of counted channels (2..16)
//   IDX_W  : width of idx, 2**IDX_W must be >= NUM_CH
//   CNT_W  : width of each counter and of data_out
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   state      in   [3:0] link FSM state, one-hot
//                   (RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000)
//   pop        in   [NUM_CH-1:0] per-channel pop strobe
//   fifo_empty in   [NUM_CH-1:0] per-channel FIFO empty flag
//   req        in   readout request
//   idx        in   [IDX_W-1:0] channel selected for readout
//   data_out   out  [CNT_W-1:0] count of the requested channel, 0 when idle
//   valid      out  data_out holds a readout this cycle
//   ovf        out  [NUM_CH-1:0] sticky per-channel saturation flag
//
// Build option:
//   CONTADOR_CLEAR_ON_READ_EN - when defined, serving a channel clears its
//   counter and overflow flag on the capturing edge. A pop accepted on that
//   edge is not part of the served value and leaves the counter at 1.
//   When undefined, readout is non-destructive.
// -----------------------------------------------------------------------------
module contador_param #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic [NUM_CH-1:0] pop,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  output logic [CNT_W-1:0]  data_out,
  output logic              valid,
  output logic [NUM_CH-1:0] ovf
);

  // Link FSM encodings (one-hot). Any other code is treated as "hold":
  // no counting, no clearing, and no readout.
  localparam logic [3:0] LINK_RESET  = 4'b0001;
  localparam logic [3:0] LINK_INIT   = 4'b0010;
  localparam logic [3:0] LINK_IDLE   = 4'b0100;
  localparam logic [3:0] LINK_ACTIVE = 4'b1000;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RD_WAIT  = 1'b0,
    RD_SERVE = 1'b1
  } rd_state_t;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic              sync_clear;
  logic              count_en;
  logic              idx_legal;
  logic              grant;
  logic [NUM_CH-1:0] accept;

  // RESET and INIT wipe everything on the next edge, like the reset pin.
  assign sync_clear = (state == LINK_RESET) || (state == LINK_INIT);
  assign count_en   = (state == LINK_ACTIVE) || (state == LINK_IDLE);
  assign accept     = pop & ~fifo_empty & {NUM_CH{count_en}};

  // idx can address more slots than exist; the extra codes are ignored.
  assign idx_legal  = (32'(idx) < NUM_CH);

  // A request is honoured only in IDLE with a legal channel. The same
  // condition drives WAIT->SERVE and SERVE->SERVE.
  assign grant      = req && (state == LINK_IDLE) && idx_legal;

  // Per-channel value offered to the readout mux, flattened so that the mux
  // can select it with a run-time index.
  logic [NUM_CH*CNT_W-1:0] serve_src_flat;

  // ---------------------------------------------------------------------------
  // Per-channel counters
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_q;
    logic             ovf_d;
`ifdef CONTADOR_CLEAR_ON_READ_EN
    logic             read_hit;

    assign read_hit = grant && (idx == IDX_W'(gi));
`endif

    always_comb begin
      cnt_inc = cnt_q;
      ovf_d   = ovf_q;
      // Saturating increment: at the top value the count holds, and the
      // lost pop is recorded in the sticky flag instead.
      if (accept[gi]) begin
        if (cnt_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_inc = cnt_q + CNT_W'(1);
        end
      end
      cnt_d = cnt_inc;
`ifdef CONTADOR_CLEAR_ON_READ_EN
      // Destructive read: restart from zero, but keep a pop that lands on
      // the capturing edge so that no word is lost between reads.
      if (read_hit) begin
        cnt_d = accept[gi] ? CNT_W'(1) : '0;
        ovf_d = 1'b0;
      end
`endif
      if (sync_clear) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign ovf[gi] = ovf_q;

`ifdef CONTADOR_CLEAR_ON_READ_EN
    // The served value excludes the same-edge pop; that pop seeds the
    // cleared counter instead.
    assign serve_src_flat[gi*CNT_W +: CNT_W] = cnt_q;
`else
    // The served value includes a pop accepted in the request cycle, so
    // the post-increment value is the one to capture.
    assign serve_src_flat[gi*CNT_W +: CNT_W] = cnt_inc;
`endif
  end

  // ---------------------------------------------------------------------------
  // Readout mux. The value is captured into data_q on the request edge, so
  // SERVE presents counter[sel] as it stood including the request cycle.
  // This is equivalent to registering sel and reading through it, and it
  // still works when clear-on-read zeroes the counter on that same edge.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] serve_val;

  always_comb begin
    serve_val = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (idx == IDX_W'(i)) begin
        serve_val = serve_src_flat[i*CNT_W +: CNT_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Readout FSM
  // ---------------------------------------------------------------------------
  rd_state_t        rd_state_q;
  rd_state_t        rd_state_d;
  logic [CNT_W-1:0] data_q;
  logic [CNT_W-1:0] data_d;

  always_comb begin
    rd_state_d = RD_WAIT;
    data_d     = '0;
    case (rd_state_q)
      RD_WAIT: begin
        if (grant) begin
          rd_state_d = RD_SERVE;
          data_d     = serve_val;
        end
      end
      RD_SERVE: begin
        // Back-to-back readout: a still-valid request re-selects the
        // channel. Otherwise the current SERVE cycle completes and the FSM
        // drops to WAIT, which also covers the link leaving IDLE.
        if (grant) begin
          rd_state_d = RD_SERVE;
          data_d     = serve_val;
        end
      end
      default: begin
        rd_state_d = RD_WAIT;
        data_d     = '0;
      end
    endcase
    if (sync_clear) begin
      rd_state_d = RD_WAIT;
      data_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= RD_WAIT;
      data_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      data_q     <= data_d;
    end
  end

  // Both outputs come straight from the asynchronously reset registers, so
  // a mid-readout reset drops them at once.
  assign valid    = (rd_state_q == RD_SERVE);
  assign data_out = data_q;

endmodule

// File: doc/contador_param.md
Name: contador_param

Overview:
- Parameterised per-channel word counter for the transaction-layer FIFO bank. Successor to the fixed 4-channel, 5-bit counter.
- Counts accepted pops on NUM_CH output FIFOs; each count saturates at its maximum and sets a sticky overflow flag.
- Serves a req/idx readout handshake while the link FSM is in IDLE, so the probe can compare totals against the words pushed.

Parameters:
- NUM_CH, 4, number of FIFO channels counted (2..16).
- IDX_W, 2, width of idx; must satisfy 2**IDX_W >= NUM_CH.
- CNT_W, 5, width of each per-channel counter and of data_out.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- state  input  4  link FSM state, one-hot: RESET=4'b0001, INIT=4'b0010, IDLE=4'b0100, ACTIVE=4'b1000.
- pop  input  NUM_CH  per-channel pop strobe issued to the FIFO.
- fifo_empty  input  NUM_CH  per-channel FIFO empty flag.
- req  input  1  readout request, sampled on clk.
- idx  input  IDX_W  channel selected for readout, sampled with req.
- data_out  output  CNT_W  count of the requested channel.
- valid  output  1  data_out is valid this cycle.
- ovf  output  NUM_CH  sticky per-channel saturation flag.

Behaviour:
- Reset (reset=1, asynchronous):
  - all counters = 0, ovf = 0, data_out = 0, valid = 0.
  - Readout FSM goes to WAIT.
- state==RESET or state==INIT (synchronous): same clearing as reset.
- Counting:
  - In ACTIVE or IDLE, on every clk edge where pop[i] & ~fifo_empty[i], counter i increments by 1.
  - A pop on an empty FIFO is ignored.
  - All channels count independently in the same cycle.
- Saturation:
  - When counter i == 2**CNT_W-1 and an accepted pop arrives, the counter holds its value and ovf[i] is set.
  - ovf[i] clears only via reset, RESET or INIT.
- Readout FSM has two states, WAIT and SERVE.
  - WAIT -> SERVE when req=1 and state==IDLE and idx < NUM_CH. Register sel = idx.
  - SERVE: valid=1 and data_out = counter[sel], reflecting all pops accepted up to and including the req cycle. Latency is exactly 1 cycle after req.
  - SERVE -> SERVE if req is still 1, idx < NUM_CH and state==IDLE; sel is re-sampled, giving one readout per cycle (back-to-back).
  - Otherwise SERVE -> WAIT, with valid=0 and data_out=0 in WAIT.
- req with idx >= NUM_CH: ignored, no valid pulse.
- req outside IDLE: ignored.
- State leaves IDLE while in SERVE: the current SERVE cycle completes, then the FSM returns to WAIT.
- Pop accepted in the same cycle as req on the selected channel: that pop is included in the served value.
- Reset asserted mid-readout: valid drops immediately (asynchronously).
- Arithmetic is unsigned, CNT_W bits, with no wrap-around.

Optional Feature:
- Macro: CONTADOR_CLEAR_ON_READ_EN.
- Defined: on each WAIT->SERVE or SERVE->SERVE transition, counter[idx] is cleared on the same edge that captures its value. An accepted pop on that channel in the same cycle leaves the counter at 1, not 0, and that pop is not in the served value. ovf[idx] is cleared along with the counter.
- Undefined: readout is non-destructive; counters persist until reset, RESET or INIT.

Test Plan:
- Reset and INIT clearing: counts = 0, ovf = 0.
  - Assert reset mid-count -> data_out=0, valid=0, counts 0, ovf=0 asynchronously.
  - Repeat via state=INIT -> counts 0 and ovf 0 on the next edge.
- Basic count: state=ACTIVE, pop channel 0 ×3, channel 2 ×7, channel 3 ×1 with FIFOs non-empty; then state=IDLE, req with idx=0,1,2,3 back-to-back -> valid high 4 consecutive cycles, data_out = 3,0,7,1.
- Empty guard: pop[1]=1 for 5 cycles with fifo_empty[1]=1 -> a readout of idx=1 returns 0.
- Saturation (CNT_W=5): 33 accepted pops on channel 2 -> readout returns 31, ovf[2]=1, other ovf bits 0.
- Illegal requests:
  - req in ACTIVE -> valid stays 0.
  - With NUM_CH=3, req idx=3 -> valid stays 0.
- Clear-on-read (macro defined): count 4 on channel 1, then read idx=1 with a simultaneous accepted pop on channel 1 -> returns 4; a second read returns 1.
